// File: rtl/led7_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package led7_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Bits needed to hold a digit index 0..n-1 (never less than one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern {g..a}.
module led7_hex_decode (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  import led7_pkg::*;

  // Standard 0-F glyphs, lower-case b and d so they differ from 8 and 0
  always_comb begin
    seg_o = SEG_OFF;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/led7_scan_driver.sv
// Multiplexed 7-segment scan driver. Inputs are snapshotted once per frame
// (at the wrap strobe) so a frame never mixes two counter values. Every digit
// change is followed by a guard interval with all anodes off to avoid ghosting.
// All state updates on the falling edge of ckht; outputs lag state by one edge.
module led7_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int GUARD_CYC      = 16,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    ckht,
  input  logic                    rst_n,
  input  logic                    ena1khz,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lzb,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [2:0]              scan_idx
);
  import led7_pkg::*;

  localparam int SW = idx_width(NUM_DIGITS);
  localparam int GW = (GUARD_CYC < 1) ? 1 : $clog2(GUARD_CYC + 1);
  localparam logic [SW-1:0] LAST     = SW'(NUM_DIGITS - 1);
  localparam logic [GW-1:0] GUARD_LD = GW'(GUARD_CYC);

  // scan position, guard countdown, first-load flag
  logic [SW-1:0] scan_q, scan_d;
  logic [GW-1:0] guard_q, guard_d;
  logic          load_pend_q, load_pend_d;

  // frame snapshot of the inputs
  logic [NUM_DIGITS-1:0][3:0] dig_sh_q, dig_sh_d;
  logic [NUM_DIGITS-1:0]      dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]      blank_sh_q, blank_sh_d;
  logic                       lzb_sh_q, lzb_sh_d;

  // output registers, already at board polarity
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  segdp_q, segdp_d;

  logic                  wrap;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [6:0]            hex_seg;
  logic [NUM_DIGITS-1:0] an_raw;
  logic [6:0]            seg_raw;
  logic                  dp_raw;
  logic                  dark;

  assign wrap = ena1khz && (scan_q == LAST);

  // Advance the scan on each strobe, run the guard down, capture a frame snapshot
  always_comb begin
    scan_d      = scan_q;
    guard_d     = guard_q;
    load_pend_d = 1'b0;
    dig_sh_d    = dig_sh_q;
    dp_sh_d     = dp_sh_q;
    blank_sh_d  = blank_sh_q;
    lzb_sh_d    = lzb_sh_q;

    if (load_pend_q || wrap) begin
      dig_sh_d   = digits;
      dp_sh_d    = dp;
      blank_sh_d = blank;
      lzb_sh_d   = lzb;
    end

    // a strobe during the guard still advances and restarts the guard
    if (ena1khz) begin
      scan_d  = (scan_q == LAST) ? '0 : scan_q + 1'b1;
      guard_d = GUARD_LD;
    end else if (guard_q != '0) begin
      guard_d = guard_q - 1'b1;
    end
  end

  // Leading-zero mask: digit i (i>0) blanks when it and every digit above are zero
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero && (dig_sh_q[i] == 4'h0);
      lz_mask[i] = lzb_sh_q && (i != 0) && all_zero;
    end
  end

  led7_hex_decode u_dec (
    .hex_i (dig_sh_q[scan_q]),
    .seg_o (hex_seg)
  );

  // Build the active-high view of the current digit, then flip to board polarity
  always_comb begin
    an_raw  = '0;
    seg_raw = SEG_OFF;
    dark    = blank_sh_q[scan_q] || lz_mask[scan_q];
    dp_raw  = dp_sh_q[scan_q] && !blank_sh_q[scan_q];
    if (guard_q == '0) an_raw[scan_q] = 1'b1;
    if (!dark) seg_raw = hex_seg;
    an_d    = an_raw ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    seg_d   = seg_raw ^ {7{SEG_ACTIVE_LOW}};
    segdp_d = dp_raw ^ SEG_ACTIVE_LOW;
  end

  // Scan and snapshot state; reset parks on digit 0 and forces a fresh load
  always_ff @(negedge ckht) begin
    if (!rst_n) begin
      scan_q      <= '0;
      guard_q     <= '0;
      load_pend_q <= 1'b1;
      dig_sh_q    <= '0;
      dp_sh_q     <= '0;
      blank_sh_q  <= '0;
      lzb_sh_q    <= 1'b0;
    end else begin
      scan_q      <= scan_d;
      guard_q     <= guard_d;
      load_pend_q <= load_pend_d;
      dig_sh_q    <= dig_sh_d;
      dp_sh_q     <= dp_sh_d;
      blank_sh_q  <= blank_sh_d;
      lzb_sh_q    <= lzb_sh_d;
    end
  end

  // Pin registers; reset drives everything to the inactive/unlit level
  always_ff @(negedge ckht) begin
    if (!rst_n) begin
      an_q    <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      seg_q   <= {7{SEG_ACTIVE_LOW}};
      segdp_q <= SEG_ACTIVE_LOW;
    end else begin
      an_q    <= an_d;
      seg_q   <= seg_d;
      segdp_q <= segdp_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign seg_dp   = segdp_q;
  assign scan_idx = 3'(scan_q);

endmodule

// File: tb/tb_led7_scan_driver.sv
// Scoreboard bench for led7_scan_driver: expected digit views are queued as
// stimulus is planned and popped as each scan step completes.
module tb_led7_scan_driver;

  localparam int N = 8;
  localparam int G = 4;

  logic        ckht    = 1'b1;
  logic        rst_n   = 1'b0;
  logic        ena1khz = 1'b0;
  logic        lzb     = 1'b0;
  logic [31:0] digits  = '0;
  logic [7:0]  dp      = '0;
  logic [7:0]  blank   = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [2:0]  scan_idx;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  obs_t sb[$];

  always #5 ckht = ~ckht;

  led7_scan_driver #(
    .NUM_DIGITS     (N),
    .GUARD_CYC      (G),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .ckht     (ckht),
    .rst_n    (rst_n),
    .ena1khz  (ena1khz),
    .digits   (digits),
    .dp       (dp),
    .blank    (blank),
    .lzb      (lzb),
    .an       (an),
    .seg      (seg),
    .seg_dp   (seg_dp),
    .scan_idx (scan_idx)
  );

  function automatic logic [6:0] pat(input logic [3:0] h);
    logic [6:0] p;
    case (h)
      4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
      4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
      4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
      4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
    endcase
    return p;
  endfunction

  // digit i lit with hex h, dp request d (board levels, active low)
  function automatic obs_t lit(input int i, input logic [3:0] h, input logic d);
    logic [7:0] one;
    one = 8'h01;
    return '{an: ~(one << i), seg: ~pat(h), dp: ~d};
  endfunction

  // digit i selected but segments dark; dp may still be lit
  function automatic obs_t dark(input int i, input logic d);
    logic [7:0] one;
    one = 8'h01;
    return '{an: ~(one << i), seg: 7'h7F, dp: ~d};
  endfunction

  function automatic obs_t cur();
    return '{an: an, seg: seg, dp: seg_dp};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    ena1khz = 1'b0;
    repeat (3) @(posedge ckht);
    rst_n = 1'b1;
    repeat (3) @(posedge ckht);
  endtask

  // one strobe, then settle 48 cycles; counts cycles with all anodes off
  task automatic step(output int ffc, output obs_t o);
    ffc = 0;
    @(posedge ckht); ena1khz = 1'b1;
    @(posedge ckht); ena1khz = 1'b0;
    for (int k = 0; k < 48; k++) begin
      @(posedge ckht);
      if (an === 8'hFF) ffc++;
    end
    o = cur();
  endtask

  task automatic test_reset();
    digits = 32'h1234_5678; ena1khz = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge ckht);
    n_cmp++;
    if (an !== 8'hFF || seg !== 7'h7F || seg_dp !== 1'b1 || scan_idx !== 3'd0) begin
      n_bad++;
      $display("FAIL reset: an=%h seg=%h dp=%b idx=%0d, want an=ff seg=7f dp=1 idx=0",
               an, seg, seg_dp, scan_idx);
    end
    ena1khz = 1'b0;
  endtask

  task automatic test_lzb_guard();
    obs_t o, e;
    int   ffc;
    digits = 32'h0000_1234; lzb = 1'b1; dp = '0; blank = '0;
    do_reset();
    sb.push_back(lit(0, 4'd4, 1'b0));
    for (int i = 1; i < 4; i++) sb.push_back(lit(i, 4'(4 - i), 1'b0));
    for (int i = 4; i < N; i++) sb.push_back(dark(i, 1'b0));
    sb.push_back(lit(0, 4'd4, 1'b0));
    o = cur(); e = sb.pop_front(); n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL lzb_start: got %h want %h", o, e);
    end
    for (int s = 1; s <= N; s++) begin
      step(ffc, o); e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL lzb_step%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 s, o.an, o.seg, o.dp, e.an, e.seg, e.dp);
      end
      n_cmp++;
      if (ffc !== G) begin
        n_bad++;
        $display("FAIL guard_len%0d: got %0d cycles want %0d", s, ffc, G);
      end
    end
  endtask

  task automatic test_frame_coherent();
    obs_t o, e;
    int   ffc;
    digits = 32'h1111_1111; lzb = 1'b0; dp = '0; blank = '0;
    do_reset();
    for (int i = 0; i < N; i++) sb.push_back(lit(i, 4'd1, 1'b0));
    for (int i = 0; i < 3; i++) sb.push_back(lit(i, 4'd2, 1'b0));
    o = cur(); e = sb.pop_front(); n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL coh_start: got %h want %h", o, e);
    end
    for (int s = 1; s <= N + 2; s++) begin
      step(ffc, o); e = sb.pop_front();
      if (s == 3) digits = 32'h2222_2222;
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL coh_step%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 s, o.an, o.seg, o.dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  task automatic test_zero_dp_blank();
    obs_t o, e;
    int   ffc;
    digits = '0; lzb = 1'b1; dp = 8'h04; blank = '0;
    do_reset();
    sb.push_back(lit(0, 4'd0, 1'b0));
    sb.push_back(dark(1, 1'b0));
    sb.push_back(dark(2, 1'b1));
    for (int i = 3; i < N; i++) sb.push_back(dark(i, 1'b0));
    sb.push_back(lit(0, 4'd0, 1'b0));
    sb.push_back(dark(1, 1'b0));
    sb.push_back(dark(2, 1'b0));
    o = cur(); e = sb.pop_front(); n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL zero_start: got %h want %h", o, e);
    end
    for (int s = 1; s <= N + 2; s++) begin
      step(ffc, o); e = sb.pop_front();
      if (s == 2) blank = 8'h04;
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL zero_step%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 s, o.an, o.seg, o.dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    int   ffc;
    digits = 32'h7654_3210; lzb = 1'b0; dp = '0; blank = '0;
    do_reset();
    for (int s = 1; s < N; s++) begin
      step(ffc, o);
    end
    n_cmp++;
    if (scan_idx !== 3'd7) begin
      n_bad++;
      $display("FAIL wrap_pre: idx=%0d want 7", scan_idx);
    end
    for (int s = 0; s < N; s++) sb.push_back(lit(s, 4'(s), 1'b0));
    for (int s = 0; s < N; s++) begin
      step(ffc, o); e = sb.pop_front();
      n_cmp++;
      if (o !== e || scan_idx !== 3'(s)) begin
        n_bad++;
        $display("FAIL wrap_step%0d: idx=%0d an=%h seg=%h want idx=%0d an=%h seg=%h",
                 s, scan_idx, o.an, o.seg, s, e.an, e.seg);
      end
    end
    // three consecutive strobes: 7 -> 0 -> 1 -> 2, anodes stay off throughout
    sb.push_back(lit(2, 4'd2, 1'b0));
    ffc = 0;
    @(posedge ckht); ena1khz = 1'b1;
    @(posedge ckht);
    for (int k = 2; k <= 7; k++) begin
      @(posedge ckht);
      if (k == 3) ena1khz = 1'b0;
      if (an === 8'hFF) ffc++;
    end
    n_cmp++;
    if (ffc !== 6) begin
      n_bad++;
      $display("FAIL b2b_guard: got %0d dark cycles want 6", ffc);
    end
    @(posedge ckht);
    o = cur(); e = sb.pop_front();
    n_cmp++;
    if (o !== e || scan_idx !== 3'd2) begin
      n_bad++;
      $display("FAIL b2b_after: idx=%0d an=%h seg=%h want idx=2 an=%h seg=%h",
               scan_idx, o.an, o.seg, e.an, e.seg);
    end
  endtask

  task automatic test_reset_mid_guard();
    obs_t o, e;
    int   ffc;
    digits = 32'hABCD_EF01; lzb = 1'b0; dp = '0; blank = '0;
    do_reset();
    for (int s = 0; s < 4; s++) step(ffc, o);
    @(posedge ckht); ena1khz = 1'b1;
    @(posedge ckht); ena1khz = 1'b0;
    n_cmp++;
    if (scan_idx !== 3'd5) begin
      n_bad++;
      $display("FAIL rst_pre: idx=%0d want 5", scan_idx);
    end
    @(posedge ckht);
    rst_n = 1'b0; digits = 32'h0000_0009; lzb = 1'b1;
    @(posedge ckht);
    n_cmp++;
    if (scan_idx !== 3'd0 || an !== 8'hFF || seg !== 7'h7F || seg_dp !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid: idx=%0d an=%h seg=%h dp=%b want idx=0 an=ff seg=7f dp=1",
               scan_idx, an, seg, seg_dp);
    end
    rst_n = 1'b1;
    sb.push_back(lit(0, 4'd9, 1'b0));
    sb.push_back(dark(1, 1'b0));
    repeat (3) @(posedge ckht);
    o = cur(); e = sb.pop_front(); n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL rst_fresh0: got %h want %h", o, e);
    end
    step(ffc, o); e = sb.pop_front(); n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL rst_fresh1: got %h want %h", o, e);
    end
  endtask

  initial begin
    test_reset();
    test_lzb_guard();
    test_frame_coherent();
    test_zero_dp_blank();
    test_back_to_back();
    test_reset_mid_guard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
